// File: rtl/rf_maint_ctrl.sv
// ============================================================================
// Module      : rf_maint_ctrl
// Description : Register-file ownership arbiter; CPU passthrough, or a stall
//               handshake followed by a sequenced clear or valid/ready dump.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_maint_ctrl #(
    parameter int                 NUM_REGS = 32,
    parameter int                 ADDR_W   = 5,
    parameter int                 DATA_W   = 8,
    parameter logic [DATA_W-1:0]  CLR_VAL  = '0
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              CMD_CLR,
    input  logic              CMD_DUMP,
    input  logic [ADDR_W-1:0] CPU_ADRX,
    input  logic [ADDR_W-1:0] CPU_ADRY,
    input  logic [DATA_W-1:0] CPU_DIN,
    input  logic              CPU_RF_WR,
    input  logic              CPU_ACK,
    output logic              CPU_STALL,
    output logic [ADDR_W-1:0] RF_ADRX,
    output logic [ADDR_W-1:0] RF_ADRY,
    output logic [DATA_W-1:0] RF_DIN,
    output logic              RF_WR,
    input  logic [DATA_W-1:0] RF_DY,
    output logic [DATA_W-1:0] DUMP_DATA,
    output logic [ADDR_W-1:0] DUMP_ADDR,
    output logic              DUMP_VALID,
    input  logic              DUMP_READY,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_CLEAR  = 3'd2;
    localparam logic [2:0] S_DUMP   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] C_IDX_STEP = ADDR_W'(1);

    logic [2:0]        state_q, state_d;
    logic              op_clr_q, op_clr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk) begin : p_state_reg
        if (RST) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            op_clr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            op_clr_q <= op_clr_d;
        end
    end

    // Commands are only sampled in IDLE; clear takes priority over dump.
    always_comb begin : p_next_state
        state_d  = state_q;
        idx_d    = idx_q;
        op_clr_d = op_clr_q;
        case (state_q)
            S_IDLE: begin
                if (CMD_CLR) begin
                    op_clr_d = 1'b1;
                    state_d  = S_REQ;
                end else if (CMD_DUMP) begin
                    op_clr_d = 1'b0;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (CPU_ACK) begin
                    idx_d   = '0;
                    state_d = op_clr_q ? S_CLEAR : S_DUMP;
                end
            end
            S_CLEAR: begin
                if (idx_q == C_LAST_IDX) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d = idx_q + C_IDX_STEP;
                end
            end
            S_DUMP: begin
                if (DUMP_READY) begin
                    if (idx_q == C_LAST_IDX) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d = idx_q + C_IDX_STEP;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin : p_outputs
        RF_ADRX    = CPU_ADRX;
        RF_ADRY    = CPU_ADRY;
        RF_DIN     = CPU_DIN;
        RF_WR      = CPU_RF_WR;
        CPU_STALL  = 1'b0;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        DUMP_VALID = 1'b0;
        DUMP_DATA  = '0;
        DUMP_ADDR  = '0;
        case (state_q)
            S_REQ: begin
                CPU_STALL = 1'b1;
                BUSY      = 1'b1;
            end
            S_CLEAR: begin
                RF_ADRX   = idx_q;
                RF_ADRY   = idx_q;
                RF_DIN    = CLR_VAL;
                RF_WR     = 1'b1;
                CPU_STALL = 1'b1;
                BUSY      = 1'b1;
            end
            S_DUMP: begin
                RF_ADRX    = idx_q;
                RF_ADRY    = idx_q;
                RF_WR      = 1'b0;
                CPU_STALL  = 1'b1;
                BUSY       = 1'b1;
                DUMP_VALID = 1'b1;
                DUMP_ADDR  = idx_q;
                DUMP_DATA  = RF_DY;
            end
            S_FINISH: begin
                BUSY = 1'b1;
                DONE = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_rf_maint_ctrl.sv
// ============================================================================
// Module      : tb_rf_maint_ctrl
// Description : Directed/randomised bench for rf_maint_ctrl with a 32x8
//               register file model and an expected-contents reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_maint_ctrl;

    localparam int          NR = 32;
    localparam int          AW = 5;
    localparam int          DW = 8;
    localparam logic [7:0]  CV = 8'h00;

    logic          clk = 1'b0;
    logic          RST, CMD_CLR, CMD_DUMP, CPU_RF_WR, CPU_ACK, DUMP_READY;
    logic [AW-1:0] CPU_ADRX, CPU_ADRY;
    logic [DW-1:0] CPU_DIN;
    logic          CPU_STALL, RF_WR, DUMP_VALID, BUSY, DONE;
    logic [AW-1:0] RF_ADRX, RF_ADRY, DUMP_ADDR;
    logic [DW-1:0] RF_DIN, RF_DY, DUMP_DATA;

    always #5 clk = ~clk;

    rf_maint_ctrl #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .CLR_VAL(CV)) dut (
        .clk(clk), .RST(RST), .CMD_CLR(CMD_CLR), .CMD_DUMP(CMD_DUMP),
        .CPU_ADRX(CPU_ADRX), .CPU_ADRY(CPU_ADRY), .CPU_DIN(CPU_DIN),
        .CPU_RF_WR(CPU_RF_WR), .CPU_ACK(CPU_ACK), .CPU_STALL(CPU_STALL),
        .RF_ADRX(RF_ADRX), .RF_ADRY(RF_ADRY), .RF_DIN(RF_DIN), .RF_WR(RF_WR),
        .RF_DY(RF_DY), .DUMP_DATA(DUMP_DATA), .DUMP_ADDR(DUMP_ADDR),
        .DUMP_VALID(DUMP_VALID), .DUMP_READY(DUMP_READY), .BUSY(BUSY), .DONE(DONE)
    );

    // Register file: synchronous write, asynchronous read on Y.
    logic [7:0] rf [0:NR-1];
    always @(posedge clk) if (RF_WR) rf[RF_ADRX] <= RF_DIN;
    assign RF_DY = rf[RF_ADRY];

    int done_cnt = 0;
    always @(posedge clk) if (DONE) done_cnt <= done_cnt + 1;

    logic [7:0] exp_rf [0:NR-1];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        CMD_CLR    = 1'b0;
        CMD_DUMP   = 1'b0;
        CPU_RF_WR  = 1'b0;
        CPU_ACK    = 1'b0;
        DUMP_READY = 1'b0;
        CPU_ADRX   = AW'($urandom);
        CPU_ADRY   = AW'($urandom);
        CPU_DIN    = DW'($urandom);
    endtask

    task automatic cpu_noise();
        CPU_RF_WR = 1'($urandom);
        CPU_ADRX  = AW'($urandom);
        CPU_ADRY  = AW'($urandom);
        CPU_DIN   = DW'($urandom);
        CPU_ACK   = 1'($urandom);
    endtask

    // mode 0: r[i]=i*3, 1: random, 2: all 8'hFF
    task automatic preload(input int mode);
        for (int i = 0; i < NR; i++) begin
            logic [7:0] v;
            v = (mode == 0) ? 8'(i * 3) : (mode == 1) ? 8'($urandom) : 8'hFF;
            CPU_ADRX  = AW'(i);
            CPU_DIN   = v;
            CPU_RF_WR = 1'b1;
            exp_rf[i] = v;
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic verify_rf(input string tag);
        for (int i = 0; i < NR; i++) check(tag, {24'd0, rf[i]}, {24'd0, exp_rf[i]});
    endtask

    task automatic req_phase(input int ack_dly, input bit cpu_wr_req);
        for (int k = 0; k < ack_dly; k++) begin
            CPU_ACK   = 1'b0;
            CPU_RF_WR = 1'b0;
            if (cpu_wr_req && k == 0) begin
                CPU_ADRX  = 5'd7;
                CPU_DIN   = 8'h3C;
                CPU_RF_WR = 1'b1;
                exp_rf[7] = 8'h3C;
            end
            #1;
            check("req_stall", CPU_STALL, 1);
            check("req_busy", BUSY, 1);
            if (cpu_wr_req && k == 0) begin
                check("req_pass_wr", RF_WR, 1);
                check("req_pass_adrx", RF_ADRX, 7);
            end
            if (cpu_wr_req && k == 1) check("req_wr_landed", rf[7], 8'h3C);
            @(negedge clk);
        end
        CPU_RF_WR = 1'b0;
        CPU_ACK   = 1'b1;
        #1;
        check("req_ack_stall", CPU_STALL, 1);
        @(negedge clk);
    endtask

    task automatic finish_phase(input int d0);
        CPU_RF_WR  = 1'b0;
        CPU_ACK    = 1'b0;
        CMD_DUMP   = 1'b1;
        CMD_CLR    = 1'($urandom);
        DUMP_READY = 1'($urandom);
        CPU_ADRX   = AW'($urandom);
        #1;
        check("fin_done", DONE, 1);
        check("fin_stall", CPU_STALL, 0);
        check("fin_busy", BUSY, 1);
        check("fin_valid", DUMP_VALID, 0);
        check("fin_dump_addr", DUMP_ADDR, 0);
        check("fin_pass_adrx", RF_ADRX, CPU_ADRX);
        check("fin_rf_wr", RF_WR, 0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("post_busy", BUSY, 0);
        check("post_done", DONE, 0);
        check("done_count", done_cnt - d0, 1);
        @(negedge clk);
    endtask

    task automatic run_clear(input int ack_dly, input bit both_cmd, input bit dump_mid,
                             input bit cpu_wr_req, input int rst_at);
        int d0;
        d0       = done_cnt;
        CMD_CLR  = 1'b1;
        CMD_DUMP = both_cmd;
        #1;
        check("clr_cmd_idle", BUSY, 0);
        @(negedge clk);
        CMD_CLR  = 1'b0;
        CMD_DUMP = 1'b0;
        req_phase(ack_dly, cpu_wr_req);
        for (int i = 0; i < NR; i++) begin
            cpu_noise();
            CMD_DUMP = dump_mid && (i == 10);
            RST      = (i == rst_at);
            #1;
            check("clr_wr", RF_WR, 1);
            check("clr_adrx", RF_ADRX, i);
            check("clr_din", RF_DIN, CV);
            check("clr_stall", CPU_STALL, 1);
            check("clr_valid", DUMP_VALID, 0);
            check("clr_done", DONE, 0);
            exp_rf[i] = CV;
            @(negedge clk);
            if (i == rst_at) begin
                idle_inputs();
                RST = 1'b0;
                #1;
                check("rst_busy", BUSY, 0);
                check("rst_stall", CPU_STALL, 0);
                check("rst_done", DONE, 0);
                check("rst_no_done", done_cnt - d0, 0);
                @(negedge clk);
                return;
            end
        end
        CMD_DUMP = 1'b0;
        finish_phase(d0);
    endtask

    task automatic run_dump(input int ack_dly, input int mode);
        int d0, beat, cycles;
        bit rdy;
        d0       = done_cnt;
        CMD_DUMP = 1'b1;
        @(negedge clk);
        CMD_DUMP = 1'b0;
        req_phase(ack_dly, 1'b0);
        beat   = 0;
        cycles = 0;
        while (beat < NR) begin
            cpu_noise();
            rdy        = (mode == 0) ? (cycles % 3 == 0) : 1'($urandom);
            DUMP_READY = rdy;
            #1;
            check("dmp_valid", DUMP_VALID, 1);
            check("dmp_addr", DUMP_ADDR, beat);
            check("dmp_data", DUMP_DATA, exp_rf[beat]);
            check("dmp_rf_wr", RF_WR, 0);
            check("dmp_stall", CPU_STALL, 1);
            if (rdy) beat++;
            cycles++;
            @(negedge clk);
            if (cycles > 1000) begin
                check("dmp_timeout", beat, NR);
                break;
            end
        end
        finish_phase(d0);
    endtask

    initial begin
        idle_inputs();
        RST       = 1'b1;
        CMD_CLR   = 1'b1;
        CPU_ADRX  = 5'd5;
        CPU_DIN   = 8'hA5;
        CPU_RF_WR = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_busy0", BUSY, 0);
        check("rst_stall0", CPU_STALL, 0);
        check("rst_valid0", DUMP_VALID, 0);
        check("rst_done0", DONE, 0);
        check("rst_dump_data0", DUMP_DATA, 0);
        check("rst_dump_addr0", DUMP_ADDR, 0);
        check("rst_pass_wr", RF_WR, 1);
        check("rst_pass_adrx", RF_ADRX, 5);
        check("rst_pass_din", RF_DIN, 8'hA5);
        @(negedge clk);
        RST = 1'b0;
        idle_inputs();
        #1;
        check("post_rst_busy", BUSY, 0);
        @(negedge clk);

        preload(2);
        run_clear(3, 1'b0, 1'b0, 1'b0, -1);
        verify_rf("clear_rf");

        preload(0);
        run_dump(0, 0);
        verify_rf("dump_rf");

        preload(1);
        run_dump($urandom_range(0, 4), 1);
        verify_rf("dump2_rf");

        preload(1);
        run_clear(4, 1'b0, 1'b0, 1'b1, -1);
        verify_rf("req_clear_rf");

        preload(1);
        run_clear($urandom_range(0, 3), 1'b1, 1'b1, 1'b0, -1);
        verify_rf("both_cmd_rf");

        preload(1);
        run_clear(2, 1'b0, 1'b0, 1'b0, 10);
        verify_rf("rst_mid_rf");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
